bpf_run_ctrl: RTL and testbench

Run-sequencer for the BPF filter cpu. It accepts one packet-filter job at a time and clears the cpu program counter. It then enables execution and watches for RET, a fault, an abort or a step-limit timeout. It returns a verdict (accept/truncation length/status) over a valid/ready result channel. It sits between the packet front end and the cpu core and owns the cpu's run enable.

---
 rtl/bpf_run_ctrl.sv | 139 +++++++++++++
 tb/tb_bpf_run_ctrl.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/bpf_run_ctrl.sv
// Run sequencer for the BPF filter cpu: clears the pc, runs the job until
// RET / fault / abort / step limit, and hands back a registered verdict.
module bpf_run_ctrl #(
    parameter int MAX_STEPS = 4096,
    parameter int CNT_W     = 16,
    parameter int RET_W     = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [15:0]      start_len,
    input  logic             abort,
    output logic             cpu_pc_clr,
    output logic             cpu_run,
    input  logic             cpu_ret,
    input  logic [RET_W-1:0] cpu_ret_val,
    input  logic             cpu_fault,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             res_accept,
    output logic [RET_W-1:0] res_len,
    output logic [1:0]       res_status,
    output logic [CNT_W-1:0] res_steps,
    output logic             busy
);

    typedef enum logic [1:0] {IDLE, CLEAR, RUN, DONE} state_t;

    localparam logic [1:0] ST_OK      = 2'd0;
    localparam logic [1:0] ST_FAULT   = 2'd1;
    localparam logic [1:0] ST_TIMEOUT = 2'd2;
    localparam logic [1:0] ST_ABORT   = 2'd3;

    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(MAX_STEPS - 1);
    localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);

    state_t           state_q;
    logic [15:0]      len_q;
    logic [CNT_W-1:0] cnt_q;
    logic             pc_clr_q, run_q, res_valid_q, res_accept_q;
    logic [RET_W-1:0] res_len_q;
    logic [1:0]       res_status_q;
    logic [CNT_W-1:0] res_steps_q;

    logic             exit_d;
    logic [1:0]       status_d;
    logic [RET_W-1:0] ret_d, len_ext, res_len_d;

    // RUN exit decode in priority order; only consulted while in RUN.
    always_comb begin
        exit_d   = 1'b1;
        status_d = ST_OK;
        ret_d    = '0;
        if (cpu_ret) begin
            ret_d = cpu_ret_val;
        end else if (cpu_fault) begin
            status_d = ST_FAULT;
        end else if (abort) begin
            status_d = ST_ABORT;
        end else if (cnt_q == LAST_STEP) begin
            status_d = ST_TIMEOUT;
        end else begin
            exit_d = 1'b0;
        end
        len_ext   = RET_W'(len_q);
        res_len_d = (ret_d < len_ext) ? ret_d : len_ext;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            len_q        <= '0;
            cnt_q        <= '0;
            pc_clr_q     <= 1'b0;
            run_q        <= 1'b0;
            res_valid_q  <= 1'b0;
            res_accept_q <= 1'b0;
            res_len_q    <= '0;
            res_status_q <= ST_OK;
            res_steps_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_valid) begin
                        len_q    <= start_len;
                        pc_clr_q <= 1'b1;
                        state_q  <= CLEAR;
                    end
                end
                CLEAR: begin
                    pc_clr_q <= 1'b0;
                    cnt_q    <= '0;
                    if (abort) begin
                        res_valid_q  <= 1'b1;
                        res_accept_q <= 1'b0;
                        res_len_q    <= '0;
                        res_status_q <= ST_ABORT;
                        res_steps_q  <= '0;
                        state_q      <= DONE;
                    end else begin
                        run_q   <= 1'b1;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    cnt_q <= cnt_q + ONE;
                    if (exit_d) begin
                        run_q        <= 1'b0;
                        res_valid_q  <= 1'b1;
                        res_accept_q <= (res_len_d != '0);
                        res_len_q    <= res_len_d;
                        res_status_q <= status_d;
                        res_steps_q  <= cnt_q + ONE;
                        state_q      <= DONE;
                    end
                end
                DONE: begin
                    if (res_ready) begin
                        res_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign start_ready = (state_q == IDLE);
    assign busy        = (state_q != IDLE);
    assign cpu_pc_clr  = pc_clr_q;
    assign cpu_run     = run_q;
    assign res_valid   = res_valid_q;
    assign res_accept  = res_accept_q;
    assign res_len     = res_len_q;
    assign res_status  = res_status_q;
    assign res_steps   = res_steps_q;

endmodule

// File: tb/tb_bpf_run_ctrl.sv
// Directed bench for bpf_run_ctrl with a short step limit so timeout is reachable.
module tb_bpf_run_ctrl;

    localparam int MAX_STEPS = 8;
    localparam int CNT_W     = 16;
    localparam int RET_W     = 32;

    logic             clk = 1'b0;
    logic             rst;
    logic             start_valid, start_ready;
    logic [15:0]      start_len;
    logic             abort, cpu_pc_clr, cpu_run, cpu_ret, cpu_fault;
    logic [RET_W-1:0] cpu_ret_val;
    logic             res_valid, res_ready, res_accept, busy;
    logic [RET_W-1:0] res_len;
    logic [1:0]       res_status;
    logic [CNT_W-1:0] res_steps;

    int n_assert = 0;
    int n_fail   = 0;
    int pc_pulses = 0;

    bpf_run_ctrl #(.MAX_STEPS(MAX_STEPS), .CNT_W(CNT_W), .RET_W(RET_W)) dut (
        .clk(clk), .rst(rst),
        .start_valid(start_valid), .start_ready(start_ready), .start_len(start_len),
        .abort(abort), .cpu_pc_clr(cpu_pc_clr), .cpu_run(cpu_run),
        .cpu_ret(cpu_ret), .cpu_ret_val(cpu_ret_val), .cpu_fault(cpu_fault),
        .res_valid(res_valid), .res_ready(res_ready), .res_accept(res_accept),
        .res_len(res_len), .res_status(res_status), .res_steps(res_steps),
        .busy(busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (cpu_pc_clr === 1'b1) pc_pulses++;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Handshake a job; returns with the DUT in CLEAR.
    task automatic launch(input logic [15:0] len);
        start_valid = 1'b1;
        start_len   = len;
        tick();
        start_valid = 1'b0;
    endtask

    task automatic retire();
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
    endtask

    initial begin
        int p0;
        rst = 1'b0; start_valid = 0; start_len = 0; abort = 0;
        cpu_ret = 0; cpu_fault = 0; cpu_ret_val = 0; res_ready = 0;
        tick(); tick();
        chk("rst_run", cpu_run, 0);
        chk("rst_valid", res_valid, 0);
        rst = 1'b1;
        tick();
        chk("idle_ready", start_ready, 1);
        chk("idle_busy", busy, 0);
        chk("idle_run", cpu_run, 0);
        chk("idle_valid", res_valid, 0);
        chk("idle_len", res_len, 0);
        chk("idle_steps", res_steps, 0);

        // Normal accept: RET on the 5th RUN cycle, length clipped to 60
        p0 = pc_pulses;
        launch(16'd60);
        chk("acc_pcclr", cpu_pc_clr, 1);
        chk("acc_clr_run", cpu_run, 0);
        chk("acc_clr_ready", start_ready, 0);
        chk("acc_clr_busy", busy, 1);
        tick();
        chk("acc_run1", cpu_run, 1);
        chk("acc_pcclr_off", cpu_pc_clr, 0);
        tick(); tick(); tick(); tick();
        cpu_ret = 1; cpu_ret_val = 32'hFFFF_FFFF;
        tick();
        cpu_ret = 0;
        chk("acc_valid", res_valid, 1);
        chk("acc_run_off", cpu_run, 0);
        chk("acc_status", res_status, 0);
        chk("acc_len", res_len, 60);
        chk("acc_accept", res_accept, 1);
        chk("acc_steps", res_steps, 5);
        chk("acc_pulses", pc_pulses - p0, 1);
        retire();
        chk("acc_back_idle", start_ready, 1);
        chk("acc_valid_off", res_valid, 0);
        chk("acc_len_held", res_len, 60);

        // Reject: RET with 0 on the first RUN cycle, verdict at t+3
        launch(16'd100);
        tick();
        cpu_ret = 1; cpu_ret_val = 0;
        tick();
        cpu_ret = 0;
        chk("rej_valid_t3", res_valid, 1);
        chk("rej_accept", res_accept, 0);
        chk("rej_len", res_len, 0);
        chk("rej_steps", res_steps, 1);
        retire();

        // Timeout after MAX_STEPS RUN cycles, then backpressure
        launch(16'd50);
        tick();
        for (int i = 0; i < MAX_STEPS - 1; i++) tick();
        chk("to_last_run", cpu_run, 1);
        chk("to_not_yet", res_valid, 0);
        tick();
        chk("to_valid", res_valid, 1);
        chk("to_status", res_status, 2);
        chk("to_steps", res_steps, 8);
        chk("to_len", res_len, 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("bp_valid", res_valid, 1);
            chk("bp_status", res_status, 2);
            chk("bp_steps", res_steps, 8);
            chk("bp_ready", start_ready, 0);
            chk("bp_run", cpu_run, 0);
        end
        retire();
        chk("to_idle", busy, 0);
        chk("to_valid_off", res_valid, 0);

        // Priority: RET beats fault and abort
        launch(16'd40);
        tick();
        cpu_ret = 1; cpu_fault = 1; abort = 1; cpu_ret_val = 20;
        tick();
        cpu_ret = 0; cpu_fault = 0; abort = 0;
        chk("pri_status", res_status, 0);
        chk("pri_len", res_len, 20);
        chk("pri_accept", res_accept, 1);
        retire();

        // Fault alone on the 2nd RUN cycle; ret value ignored
        launch(16'd40);
        tick(); tick();
        cpu_fault = 1; cpu_ret_val = 99;
        tick();
        cpu_fault = 0;
        chk("flt_status", res_status, 1);
        chk("flt_len", res_len, 0);
        chk("flt_accept", res_accept, 0);
        chk("flt_steps", res_steps, 2);
        retire();

        // Abort while in CLEAR
        launch(16'd30);
        abort = 1;
        tick();
        abort = 0;
        chk("ab_valid", res_valid, 1);
        chk("ab_status", res_status, 3);
        chk("ab_steps", res_steps, 0);
        chk("ab_run", cpu_run, 0);
        retire();

        // Reset mid-RUN, then a fresh job
        launch(16'd30);
        tick(); tick();
        chk("mid_run", cpu_run, 1);
        rst = 1'b0;
        #1;
        chk("rst_async_run", cpu_run, 0);
        chk("rst_async_busy", busy, 0);
        chk("rst_async_valid", res_valid, 0);
        chk("rst_async_len", res_len, 0);
        tick();
        rst = 1'b1;
        tick();
        launch(16'd10);
        tick();
        cpu_ret = 1; cpu_ret_val = 7;
        tick();
        cpu_ret = 0;
        chk("post_valid", res_valid, 1);
        chk("post_len", res_len, 7);
        chk("post_steps", res_steps, 1);
        retire();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
